fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the 5-stage pipelined CPU. It owns the program counter, drives the byte address of the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. It applies hazard-unit stalls and branch redirects from later stages. It can trap out-of-range or misaligned fetches before they reach the ROM.

## Interface
Parameters:
- MEM_SIZE, 1024: instruction ROM size in bytes; must be a power of two and greater than 4.
- RESET_PC, 64'd0: PC value loaded on reset.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- stall, input, 1: hazard-unit hold request for the IF stage.
- redirect, input, 1: taken branch or jump from a later stage; squashes the fetch in flight.
- redirect_target, input, 64: byte address to fetch next when redirect=1.
- imem_addr, output, 64: byte address to the ROM; combinationally equal to pc.
- imem_instr, input, 32: ROM read data for imem_addr; valid in the same cycle.
- ifid_pc, output, 64: PC of the instruction held in IF/ID.
- ifid_instr, output, 32: instruction held in IF/ID.
- ifid_valid, output, 1: IF/ID holds a real instruction; 0 means bubble.
- fault, output, 1: sticky fetch-fault flag.
- fetch_count, output, 32: number of instructions delivered into IF/ID.

## Operation
- State machine with two states, RUN and FAULT. Reset enters RUN.
- Per-edge priority in RUN, highest first: reset, redirect, fault detect, stall, normal fetch.
- **redirect=1:**
  - pc <= redirect_target.
  - ifid_valid <= 0.
  - ifid_pc and ifid_instr hold their values.
  - fetch_count is unchanged.
  - redirect overrides stall in the same cycle.
- **Fault detect** (only with the macro enabled, only when redirect=0): if pc[1:0]!=0 or pc+3 >= MEM_SIZE, the block moves to FAULT and sets ifid_valid <= 0 and fault <= 1. This check applies even when stall=1.
- **stall=1:** pc, ifid_pc, ifid_instr, ifid_valid and fetch_count all hold.
- **Normal fetch:**
  - ifid_pc <= pc, ifid_instr <= imem_instr, ifid_valid <= 1.
  - pc <= pc+4, using 64-bit wrap arithmetic.
  - fetch_count <= fetch_count+1, wrapping at 2^32.
- **FAULT state:**
  - pc freezes.
  - ifid_valid stays 0 and fault stays 1.
  - stall and redirect are ignored.
  - Only reset exits FAULT.
- imem_addr always equals pc. It is driven in FAULT as well, so the ROM's own assertions still observe the address.

## Timing
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - ifid_pc = 0, ifid_instr = 0, ifid_valid = 0.
  - fault = 0, fetch_count = 0.
- Fetch latency: the word at address A appears in IF/ID exactly one edge after pc=A, provided that edge has no stall and no redirect.
- Redirect penalty: the redirect edge inserts one bubble. The target instruction is valid in IF/ID on the following unstalled edge.
- Stall held for N cycles freezes the outputs for N cycles. The first unstalled edge resumes fetching from the held pc, with no lost or duplicated instruction.
- Reset asserted mid-operation, including in FAULT or during a stall, takes effect on that edge and returns every output to its reset value.
- Throughput is one instruction per cycle when there are no stalls or redirects.

## Configuration
- FETCH_BOUNDS_CHECK_EN:
  - Defined: the fault detect described under Operation is compiled in, and the FAULT state is reachable.
  - Undefined: the check logic is absent, fault is tied to 0, the block never leaves RUN, and out-of-range addresses are passed to the ROM unchanged.

## Test plan
- **Reset and sequential fetch:** ROM word i = i. Deassert reset and run 4 cycles with no stall. Required: ifid_pc = 0, 4, 8, 12 with ifid_instr = 0, 1, 2, 3; first ifid_valid=1 one edge after reset drops; fetch_count = 4.
- **Stall:** at pc=8, hold stall=1 for 3 cycles. Required: outputs frozen for 3 edges; next edge gives ifid_pc=8 and ifid_instr=2; no skipped or repeated instruction.
- **Redirect beats stall:** at pc=12, apply redirect=1, redirect_target=64 and stall=1 together. Required: ifid_valid=0 on that edge; next edge gives ifid_pc=64 and ifid_instr=16; fetch_count not incremented on the bubble edge.
- **Misaligned target (macro defined):** redirect_target=0x22. Required: fault=1 and ifid_valid=0 one edge after pc becomes 0x22; pc holds 0x22 with further redirects ignored; asserting reset clears fault and sets pc=0.
- **Upper bound (macro defined):** sequential fetch with MEM_SIZE=1024. Required: pc=1020 fetches normally; pc=1024 raises fault. With the macro undefined, the same run gives fault=0 and imem_addr=1024.
- **Reset mid-stall:** reset=1 while stall=1 and ifid_valid=1. Required: next edge gives ifid_valid=0, pc=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fetch_if
// Brief   : IF-stage bus: hazard/redirect inputs, ROM port and IF/ID outputs.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
interface fetch_if;
   logic        stall;
   logic        redirect;
   logic [63:0] redirect_target;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        fault;
   logic [31:0] fetch_count;

   modport master (
      input  stall, redirect, redirect_target, imem_instr,
      output imem_addr, ifid_pc, ifid_instr, ifid_valid, fault, fetch_count
   );

   modport slave (
      output stall, redirect, redirect_target, imem_instr,
      input  imem_addr, ifid_pc, ifid_instr, ifid_valid, fault, fetch_count
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fetch_ctrl
// Brief   : PC sequencer and IF/ID register with stall, redirect and optional
//           fetch-bounds trap (enabled by FETCH_BOUNDS_CHECK_EN).
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int unsigned MEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  wire logic clk,
   input  wire logic reset,
   fetch_if.master   bus
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] count_q, count_d;
   logic        w_fetch_fault;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [63:0] C_MEM_SIZE = 64'(MEM_SIZE);

   // The last byte of the word must still lie inside the ROM.
   assign w_fetch_fault = (pc_q[1:0] != 2'b00) || ((pc_q + 64'd3) >= C_MEM_SIZE);
   assign bus.fault     = (state_q == ST_FAULT);
`else
   assign w_fetch_fault = 1'b0;
   assign bus.fault     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 64'd0;
         ifid_instr_q <= 32'd0;
         ifid_valid_q <= 1'b0;
         count_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         count_q      <= count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      count_d      = count_q;

      case (state_q)
         ST_RUN: begin
            if (bus.redirect) begin
               pc_d         = bus.redirect_target;
               ifid_valid_d = 1'b0;
            end else if (w_fetch_fault) begin
               state_d      = ST_FAULT;
               ifid_valid_d = 1'b0;
            end else if (!bus.stall) begin
               ifid_pc_d    = pc_q;
               ifid_instr_d = bus.imem_instr;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + 64'd4;
               count_d      = count_q + 32'd1;
            end
         end
         // Everything is frozen until reset; valid was already cleared on entry.
         ST_FAULT: ;
         default: state_d = ST_RUN;
      endcase
   end

   assign bus.imem_addr   = pc_q;
   assign bus.ifid_pc     = ifid_pc_q;
   assign bus.ifid_instr  = ifid_instr_q;
   assign bus.ifid_valid  = ifid_valid_q;
   assign bus.fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_fetch_ctrl
// Brief   : Scoreboard bench for fetch_ctrl with a behavioural PC/ROM model.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam int unsigned C_MEM_SIZE = 1024;
   localparam logic [63:0] C_RESET_PC = 64'd0;
`ifdef FETCH_BOUNDS_CHECK_EN
   localparam bit C_CHK = 1'b1;
`else
   localparam bit C_CHK = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] addr;
      logic        vld;
      logic [63:0] ipc;
      logic [31:0] instr;
      logic [31:0] cnt;
      logic        flt;
   } exp_t;

   logic clk;
   logic reset;
   fetch_if bus();

   fetch_ctrl #(
      .MEM_SIZE (C_MEM_SIZE),
      .RESET_PC (C_RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM: word i holds the value i.
   assign bus.imem_instr = bus.imem_addr[33:2];

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic [63:0] m_pc;
   logic        m_vld;
   logic [63:0] m_ipc;
   logic [31:0] m_instr;
   logic [31:0] m_cnt;
   logic        m_flt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: what IF/ID and the PC hold after one clock edge.
   task automatic model_edge(input logic r, input logic s, input logic d, input logic [63:0] t);
      if (r) begin
         m_pc = C_RESET_PC; m_vld = 0; m_ipc = 0; m_instr = 0; m_cnt = 0; m_flt = 0;
      end else if (m_flt) begin
      end else if (d) begin
         m_pc  = t;
         m_vld = 0;
      end else if (C_CHK && ((m_pc % 4 != 0) || (m_pc + 3 >= 64'(C_MEM_SIZE)))) begin
         m_flt = 1;
         m_vld = 0;
      end else if (!s) begin
         m_ipc   = m_pc;
         m_instr = 32'(m_pc / 4);
         m_vld   = 1;
         m_pc    = m_pc + 4;
         m_cnt   = m_cnt + 1;
      end
   endtask

   task automatic step(input logic r, input logic s, input logic d, input logic [63:0] t);
      exp_t e;
      @(negedge clk);
      reset               = r;
      bus.stall           = s;
      bus.redirect        = d;
      bus.redirect_target = t;
      model_edge(r, s, d, t);
      e.addr = m_pc; e.vld = m_vld; e.ipc = m_ipc; e.instr = m_instr;
      e.cnt = m_cnt; e.flt = m_flt;
      sb.push_back(e);
   endtask

   // Monitor: after every edge, compare DUT outputs to the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("imem_addr",   bus.imem_addr,          e.addr);
         chk("ifid_valid",  64'(bus.ifid_valid),    64'(e.vld));
         chk("ifid_pc",     bus.ifid_pc,            e.ipc);
         chk("ifid_instr",  64'(bus.ifid_instr),    64'(e.instr));
         chk("fetch_count", 64'(bus.fetch_count),   64'(e.cnt));
         chk("fault",       64'(bus.fault),         64'(e.flt));
      end
   end

   initial begin
      logic [63:0] tgt;
      reset = 1'b1; bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0;
      m_pc = 0; m_vld = 0; m_ipc = 0; m_instr = 0; m_cnt = 0; m_flt = 0;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      // Sequential fetch to pc=8, then a 3-cycle stall.
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      // pc=12: redirect and stall together.
      step(0, 1, 1, 64'd64);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // Reset during a stall with a valid instruction held.
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Upper bound: walk through the last ROM words and past the end.
      step(0, 0, 1, 64'd1012);
      repeat (5) step(0, 0, 0, 0);
      step(0, 0, 1, 64'd16);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);

      // Misaligned redirect target.
      step(0, 0, 0, 0);
      step(0, 0, 1, 64'h22);
      step(0, 0, 0, 0);
      step(0, 0, 1, 64'd8);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0)
            tgt = {$urandom(), $urandom()};
         else
            tgt = 64'($urandom_range(0, 255)) << 2;
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), tgt);
      end

      step(0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
